// File: rtl/ctrl_fsm_16bits.sv
// ctrl_fsm_16bits: multi-cycle control unit for a 16-bit load/store core.
// Sequences FETCH -> DECODE -> EXEC [-> MEM] and drives the datapath selects,
// register-file addresses and memory strobes.
// Optional feature macro: CTRL_COND_BR_EN enables the flag-conditional branch
// codes; without it only cond 000 branches and other BR codes behave as NOP.
module ctrl_fsm_16bits #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    input  logic        c,
    input  logic        n,
    input  logic        z,
    input  logic        v,
    output logic [15:0] pc,
    output logic [7:0]  instr,
    output logic [2:0]  wr_addr,
    output logic [2:0]  rd_addr_a,
    output logic [2:0]  rd_addr_b,
    output logic        alu_srca,
    output logic [1:0]  alu_srcb,
    output logic [1:0]  alu_ctrl,
    output logic        wr_e,
    output logic        e_flag,
    output logic        wb_sel,
    output logic        addr_sel,
    output logic        mem_re,
    output logic        mem_we,
    output logic        halted
);

    localparam int unsigned XLEN   = 16;
    localparam int unsigned OP_W   = 5;

    localparam logic [OP_W-1:0] OP_ADD  = 5'b00000;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00001;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00010;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00011;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b00100;
    localparam logic [OP_W-1:0] OP_LD   = 5'b00101;
    localparam logic [OP_W-1:0] OP_ST   = 5'b00110;
    localparam logic [OP_W-1:0] OP_BR   = 5'b00111;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11111;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_DISP = 2'b11;

    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;
    localparam logic [1:0] ALU_SUB = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t            r_state;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_ir;

    logic [OP_W-1:0]   w_op;
    logic [2:0]        w_rd;
    logic [2:0]        w_rs;
    logic [XLEN-1:0]   w_disp;
    logic              w_is_alu;
    logic              w_is_ld;
    logic              w_is_st;
    logic              w_is_br;
    logic              w_is_halt;
    logic              w_br_taken;

    assign w_op      = r_ir[15:11];
    assign w_rd      = r_ir[10:8];
    assign w_rs      = r_ir[7:5];
    // disp8 is a signed displacement relative to the already-incremented pc
    assign w_disp    = {{8{r_ir[7]}}, r_ir[7:0]};
    assign w_is_alu  = (w_op <= OP_ADDI);
    assign w_is_ld   = (w_op == OP_LD);
    assign w_is_st   = (w_op == OP_ST);
    assign w_is_br   = (w_op == OP_BR);
    assign w_is_halt = (w_op == OP_HALT);

`ifdef CTRL_COND_BR_EN
    // Branch condition table over the datapath flags
    always_comb begin
        case (w_rd)
            3'b000:  w_br_taken = 1'b1;
            3'b001:  w_br_taken = z;
            3'b010:  w_br_taken = ~z;
            3'b011:  w_br_taken = c;
            3'b100:  w_br_taken = n;
            3'b101:  w_br_taken = v;
            default: w_br_taken = 1'b0;
        endcase
    end
`else
    // Only the unconditional code branches; the flags are not consulted
    logic w_unused_flags;
    assign w_br_taken     = (w_rd == 3'b000);
    assign w_unused_flags = ^{c, n, z, v};
`endif

    // State, program counter and instruction register
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (mem_ready) begin
                        r_ir    <= mem_rdata;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_pc    <= r_pc + XLEN'(1);
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (w_is_br && w_br_taken) begin
                        r_pc <= r_pc + w_disp;
                    end
                    if (w_is_ld || w_is_st) begin
                        r_state <= S_MEM;
                    end else if (w_is_halt) begin
                        r_state <= S_HALT;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        r_state <= S_FETCH;
                    end
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Datapath selects and strobes decoded from state and IR; strobes are
    // masked while clr is low so an abandoned access never writes
    always_comb begin
        wr_addr   = '0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        alu_srca  = 1'b0;
        alu_srcb  = SRCB_REG;
        alu_ctrl  = ALU_AND;
        wr_e      = 1'b0;
        e_flag    = 1'b0;
        wb_sel    = 1'b0;
        addr_sel  = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_re = 1'b1;
            end
            S_DECODE: begin
                alu_srcb = SRCB_ONE;
                alu_ctrl = ALU_ADD;
            end
            S_EXEC: begin
                if (w_is_alu) begin
                    rd_addr_a = w_rd;
                    rd_addr_b = w_rs;
                    wr_addr   = w_rd;
                    alu_srca  = 1'b1;
                    alu_srcb  = (w_op == OP_ADDI) ? SRCB_IMM : SRCB_REG;
                    wr_e      = 1'b1;
                    e_flag    = 1'b1;
                    case (w_op)
                        OP_SUB:  alu_ctrl = ALU_SUB;
                        OP_AND:  alu_ctrl = ALU_AND;
                        OP_OR:   alu_ctrl = ALU_OR;
                        default: alu_ctrl = ALU_ADD;
                    endcase
                end else if (w_is_br) begin
                    alu_srcb = SRCB_DISP;
                    alu_ctrl = ALU_ADD;
                end
            end
            S_MEM: begin
                rd_addr_a = w_rs;
                alu_srca  = 1'b1;
                alu_srcb  = SRCB_IMM;
                alu_ctrl  = ALU_ADD;
                addr_sel  = 1'b1;
                if (w_is_ld) begin
                    mem_re  = 1'b1;
                    wr_addr = w_rd;
                    wb_sel  = 1'b1;
                    wr_e    = mem_ready;
                end else begin
                    mem_we    = 1'b1;
                    rd_addr_b = w_rd;
                end
            end
            default: ;
        endcase
        if (!clr) begin
            wr_e   = 1'b0;
            e_flag = 1'b0;
            mem_re = 1'b0;
            mem_we = 1'b0;
        end
    end

    assign pc     = r_pc;
    assign instr  = r_ir[7:0];
    assign halted = (r_state == S_HALT);

endmodule

// File: tb/tb_ctrl_fsm_16bits.sv
// Testbench for ctrl_fsm_16bits: directed scenarios plus a randomized
// instruction stream checked against an instruction-level reference model.
module tb_ctrl_fsm_16bits;

    localparam logic [15:0] RST_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        clr;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        c, n, z, v;
    logic [15:0] pc;
    logic [7:0]  instr;
    logic [2:0]  wr_addr, rd_addr_a, rd_addr_b;
    logic        alu_srca;
    logic [1:0]  alu_srcb, alu_ctrl;
    logic        wr_e, e_flag, wb_sel, addr_sel, mem_re, mem_we, halted;

    int checks = 0;
    int passed = 0;

    typedef struct packed {
        logic        mem_re;
        logic        mem_we;
        logic        wr_e;
        logic        e_flag;
        logic        halted;
        logic        addr_sel;
        logic        wb_sel;
        logic [2:0]  wr_addr;
        logic        alu_srca;
        logic [1:0]  alu_srcb;
        logic [1:0]  alu_ctrl;
        logic [2:0]  rd_a;
        logic [2:0]  rd_b;
        logic [15:0] pc;
        logic [7:0]  instr;
    } obs_t;

    always #5 clk = ~clk;

    ctrl_fsm_16bits #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .clr(clr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .c(c), .n(n), .z(z), .v(v),
        .pc(pc), .instr(instr), .wr_addr(wr_addr), .rd_addr_a(rd_addr_a),
        .rd_addr_b(rd_addr_b), .alu_srca(alu_srca), .alu_srcb(alu_srcb),
        .alu_ctrl(alu_ctrl), .wr_e(wr_e), .e_flag(e_flag), .wb_sel(wb_sel),
        .addr_sel(addr_sel), .mem_re(mem_re), .mem_we(mem_we), .halted(halted)
    );

    // Branch decision straight from the condition table
    function automatic logic br_taken(input logic [2:0] cond, input logic fc,
                                      input logic fn, input logic fz, input logic fv);
        logic [7:0] tbl;
        tbl = {2'b00, fv, fn, fc, ~fz, fz, 1'b1};
`ifndef CTRL_COND_BR_EN
        tbl[7:1] = '0;
`endif
        return tbl[cond];
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench one step into the first FETCH cycle with clr high
    task automatic reset_dut();
        next_cycle();
        clr = 1'b0;
        mem_ready = 1'b0;
        next_cycle();
        clr = 1'b1;
    endtask

    // Completes a fetch of ins after w wait cycles; returns at DECODE
    task automatic fetch(input logic [15:0] ins, input int w);
        for (int i = 0; i < w; i++) begin
            mem_ready = 1'b0;
            mem_rdata = 16'($urandom);
            next_cycle();
        end
        mem_ready = 1'b1;
        mem_rdata = ins;
        next_cycle();
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        next_cycle();
        clr = 1'b0; mem_ready = 1'b1; mem_rdata = 16'hFFFF; {c, n, z, v} = 4'hF;
        next_cycle(); #1;
        checks++;
        if ({pc, instr, halted} !== {RST_PC, 8'h00, 1'b0})
            $display("FAIL reset_regs: pc=%h instr=%h halted=%b, want pc=%h instr=00 halted=0", pc, instr, halted, RST_PC);
        else passed++;
        checks++;
        if ({wr_e, e_flag, mem_re, mem_we} !== 4'b0000)
            $display("FAIL reset_strobes: {wr_e,e_flag,mem_re,mem_we}=%b, want 0000", {wr_e, e_flag, mem_re, mem_we});
        else passed++;
        next_cycle(); #1;
        checks++;
        if (instr !== 8'h00)
            $display("FAIL reset_priority: instr=%h, want 00", instr);
        else passed++;
        clr = 1'b1; #1;
        checks++;
        if ({mem_re, mem_we, addr_sel} !== 3'b100)
            $display("FAIL reset_fetch: {mem_re,mem_we,addr_sel}=%b, want 100", {mem_re, mem_we, addr_sel});
        else passed++;
    endtask

    task automatic test_alu();
        reset_dut();
        mem_ready = 1'b1; mem_rdata = 16'h0140; #1;
        checks++;
        if ({mem_re, addr_sel} !== 2'b10)
            $display("FAIL alu_fetch: {mem_re,addr_sel}=%b, want 10", {mem_re, addr_sel});
        else passed++;
        next_cycle(); mem_ready = 1'b0; #1;
        checks++;
        if ({alu_srca, alu_srcb, alu_ctrl, wr_e, mem_re} !== 7'b0_01_10_0_0)
            $display("FAIL decode_sel: {srca,srcb,ctrl,wr_e,mem_re}=%b, want 0011000", {alu_srca, alu_srcb, alu_ctrl, wr_e, mem_re});
        else passed++;
        next_cycle(); #1;
        checks++;
        if (pc !== 16'h0001)
            $display("FAIL decode_pc: pc=%h, want 0001", pc);
        else passed++;
        checks++;
        if ({wr_e, wr_addr, e_flag, wb_sel, rd_addr_a, rd_addr_b, alu_ctrl} !== {1'b1, 3'd1, 1'b1, 1'b0, 3'd1, 3'd2, 2'b10})
            $display("FAIL add_exec: wr_e=%b wr_addr=%0d e_flag=%b wb_sel=%b ra=%0d rb=%0d ctrl=%b, want 1 1 1 0 1 2 10",
                     wr_e, wr_addr, e_flag, wb_sel, rd_addr_a, rd_addr_b, alu_ctrl);
        else passed++;
        next_cycle(); #1;
        checks++;
        if ({mem_re, wr_e} !== 2'b10)
            $display("FAIL alu_back_fetch: {mem_re,wr_e}=%b, want 10", {mem_re, wr_e});
        else passed++;
        mem_ready = 1'b1; mem_rdata = 16'h2204;
        next_cycle(); mem_ready = 1'b0;
        next_cycle(); #1;
        checks++;
        if ({alu_srca, alu_srcb, alu_ctrl, wr_addr, wr_e, instr, pc} !== {1'b1, 2'b10, 2'b10, 3'd2, 1'b1, 8'h04, 16'h0002})
            $display("FAIL addi_exec: srca=%b srcb=%b ctrl=%b wr_addr=%0d wr_e=%b instr=%h pc=%h, want 1 10 10 2 1 04 0002",
                     alu_srca, alu_srcb, alu_ctrl, wr_addr, wr_e, instr, pc);
        else passed++;
        next_cycle();
    endtask

    task automatic test_ld_wait();
        int  re_n;
        int  we_n;
        logic pulse_ok;
        re_n = 0; we_n = 0; pulse_ok = 1'b1;
        reset_dut();
        fetch(16'h2B20, 0);
        next_cycle(); #1;
        checks++;
        if ({wr_e, e_flag, mem_re, mem_we} !== 4'b0000)
            $display("FAIL ld_exec_quiet: {wr_e,e_flag,mem_re,mem_we}=%b, want 0000", {wr_e, e_flag, mem_re, mem_we});
        else passed++;
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            mem_ready = (i == 2); mem_rdata = 16'($urandom); #1;
            if (mem_re === 1'b1) re_n++;
            if ({addr_sel, rd_addr_a, alu_srcb} !== {1'b1, 3'd1, 2'b10}) pulse_ok = 1'b0;
            if (wr_e === 1'b1) begin
                we_n++;
                if ({wb_sel, wr_addr} !== {1'b1, 3'd3} || i != 2) pulse_ok = 1'b0;
            end
            next_cycle();
        end
        mem_ready = 1'b0; #1;
        if (wr_e !== 1'b0) we_n++;
        checks++;
        if (re_n != 3) $display("FAIL ld_re_cycles: mem_re held %0d cycles, want 3", re_n);
        else passed++;
        checks++;
        if (we_n != 1) $display("FAIL ld_wr_pulse: %0d wr_e pulses, want 1", we_n);
        else passed++;
        checks++;
        if (pulse_ok !== 1'b1) $display("FAIL ld_mem_drive: address/write-back drive ok=%b, want 1", pulse_ok);
        else passed++;
    endtask

    task automatic test_branch();
        logic [15:0] want;
        for (int k = 0; k < 2; k++) begin
            reset_dut();
            {c, n, v} = 3'b000; z = (k == 0);
            fetch(16'h3934, 0);
            next_cycle();
            next_cycle(); #1;
`ifdef CTRL_COND_BR_EN
            want = z ? 16'h0035 : 16'h0001;
`else
            want = 16'h0001;
`endif
            checks++;
            if (pc !== want) $display("FAIL br_z: z=%b pc=%h, want %h", z, pc, want);
            else passed++;
        end
        reset_dut();
        fetch(16'h38FE, 0);
        next_cycle();
        next_cycle(); #1;
        checks++;
        if (pc !== 16'hFFFF) $display("FAIL br_negative: pc=%h, want ffff", pc);
        else passed++;
        fetch(16'h4000, 0);
        next_cycle(); #1;
        checks++;
        if (pc !== 16'h0000) $display("FAIL pc_wrap: pc=%h, want 0000", pc);
        else passed++;
        next_cycle();
    endtask

    task automatic test_halt();
        reset_dut();
        fetch(16'hF800, 0);
        next_cycle();
        next_cycle();
        for (int i = 0; i < 10; i++) begin
            mem_ready = 1'($urandom); mem_rdata = 16'($urandom); #1;
            checks++;
            if ({halted, pc, wr_e, e_flag, mem_re, mem_we} !== {1'b1, 16'h0001, 4'b0000})
                $display("FAIL halt_hold: cycle %0d halted=%b pc=%h strobes=%b, want 1 0001 0000",
                         i, halted, pc, {wr_e, e_flag, mem_re, mem_we});
            else passed++;
            next_cycle();
        end
        clr = 1'b0; mem_ready = 1'b0;
        next_cycle(); clr = 1'b1; #1;
        checks++;
        if ({halted, pc, mem_re} !== {1'b0, RST_PC, 1'b1})
            $display("FAIL halt_reset: halted=%b pc=%h mem_re=%b, want 0 %h 1", halted, pc, mem_re, RST_PC);
        else passed++;
    endtask

    task automatic test_mem_reset();
        reset_dut();
        fetch(16'h3223, 0);
        next_cycle();
        next_cycle();
        mem_ready = 1'b0; #1;
        checks++;
        if ({mem_we, mem_re, addr_sel, rd_addr_a, rd_addr_b, alu_srcb} !== {1'b1, 1'b0, 1'b1, 3'd1, 3'd2, 2'b10})
            $display("FAIL st_mem_drive: we=%b re=%b asel=%b ra=%0d rb=%0d srcb=%b, want 1 0 1 1 2 10",
                     mem_we, mem_re, addr_sel, rd_addr_a, rd_addr_b, alu_srcb);
        else passed++;
        next_cycle(); clr = 1'b0;
        next_cycle(); clr = 1'b1; #1;
        checks++;
        if ({mem_we, pc, mem_re} !== {1'b0, RST_PC, 1'b1})
            $display("FAIL st_reset_abort: mem_we=%b pc=%h mem_re=%b, want 0 %h 1", mem_we, pc, mem_re, RST_PC);
        else passed++;
        reset_dut();
        fetch(16'h2B20, 0);
        next_cycle();
        next_cycle();
        mem_ready = 1'b1; clr = 1'b0; #1;
        checks++;
        if (wr_e !== 1'b0) $display("FAIL ld_reset_no_write: wr_e=%b, want 0", wr_e);
        else passed++;
        next_cycle(); clr = 1'b1; mem_ready = 1'b0; #1;
        checks++;
        if ({pc, mem_re, wr_e} !== {RST_PC, 1'b1, 1'b0})
            $display("FAIL ld_reset_fetch: pc=%h mem_re=%b wr_e=%b, want %h 1 0", pc, mem_re, wr_e, RST_PC);
        else passed++;
    endtask

    // Instruction-level model: each instruction occupies fetch (waits + 1),
    // decode, exec and, for LD/ST, mem (waits + 1) cycles
    task automatic test_random();
        obs_t        obs, want, msk;
        logic [15:0] ins, pc0, pc1;
        logic [4:0]  op;
        logic [2:0]  rd, rs;
        logic [1:0]  want_ctrl;
        logic        is_alu, is_ld, is_st, take;
        int          cls, fw, mw, ncyc;
        reset_dut();
        pc0 = RST_PC;
        for (int k = 0; k < 150; k++) begin
            cls = $urandom_range(0, 9);
            ins = 16'($urandom);
            if (cls <= 7)      ins[15:11] = 5'(cls);
            else if (cls == 8) ins[15:11] = 5'd7;
            else               ins[15:11] = 5'($urandom_range(8, 30));
            op = ins[15:11]; rd = ins[10:8]; rs = ins[7:5];
            is_alu = (op <= 5'd4); is_ld = (op == 5'd5); is_st = (op == 5'd6);
            {c, n, z, v} = 4'($urandom);
            take = (op == 5'd7) && br_taken(rd, c, n, z, v);
            fw = $urandom_range(0, 2);
            mw = $urandom_range(0, 2);
            ncyc = fw + 3 + ((is_ld || is_st) ? mw + 1 : 0);
            pc1 = pc0 + 16'd1;
            case (op)
                5'd1:    want_ctrl = 2'b11;
                5'd2:    want_ctrl = 2'b00;
                5'd3:    want_ctrl = 2'b01;
                default: want_ctrl = 2'b10;
            endcase
            for (int t = 0; t < ncyc; t++) begin
                want = '0; msk = '0;
                msk.mem_re = 1'b1; msk.mem_we = 1'b1; msk.wr_e = 1'b1;
                msk.e_flag = 1'b1; msk.halted = 1'b1; msk.pc = '1;
                mem_ready = 1'($urandom); mem_rdata = 16'($urandom);
                if (t <= fw) begin
                    mem_ready = (t == fw);
                    if (t == fw) mem_rdata = ins;
                    want.mem_re = 1'b1; msk.addr_sel = 1'b1; want.pc = pc0;
                end else begin
                    msk.instr = '1; want.instr = ins[7:0];
                    if (t == fw + 1) begin
                        want.pc = pc0;
                        msk.alu_srca = 1'b1; msk.alu_srcb = '1; msk.alu_ctrl = '1;
                        want.alu_srcb = 2'b01; want.alu_ctrl = 2'b10;
                    end else if (t == fw + 2) begin
                        want.pc = pc1;
                        if (is_alu) begin
                            want.wr_e = 1'b1; want.e_flag = 1'b1;
                            msk.wb_sel = 1'b1; msk.wr_addr = '1; msk.alu_srca = 1'b1;
                            msk.alu_srcb = '1; msk.alu_ctrl = '1; msk.rd_a = '1;
                            want.wr_addr = rd; want.alu_srca = 1'b1; want.alu_ctrl = want_ctrl;
                            want.alu_srcb = (op == 5'd4) ? 2'b10 : 2'b00; want.rd_a = rd;
                            if (op != 5'd4) begin msk.rd_b = '1; want.rd_b = rs; end
                        end else if (take) begin
                            msk.alu_srca = 1'b1; msk.alu_srcb = '1; msk.alu_ctrl = '1;
                            want.alu_srcb = 2'b11; want.alu_ctrl = 2'b10;
                        end
                    end else begin
                        want.pc = pc1;
                        mem_ready = (t == ncyc - 1);
                        msk.addr_sel = 1'b1; msk.alu_srca = 1'b1; msk.alu_srcb = '1;
                        msk.alu_ctrl = '1; msk.rd_a = '1;
                        want.addr_sel = 1'b1; want.alu_srca = 1'b1; want.alu_srcb = 2'b10;
                        want.alu_ctrl = 2'b10; want.rd_a = rs;
                        if (is_ld) begin
                            want.mem_re = 1'b1;
                            if (mem_ready) begin
                                want.wr_e = 1'b1; msk.wb_sel = 1'b1; want.wb_sel = 1'b1;
                                msk.wr_addr = '1; want.wr_addr = rd;
                            end
                        end else begin
                            want.mem_we = 1'b1; msk.rd_b = '1; want.rd_b = rd;
                        end
                    end
                end
                #1;
                obs = {mem_re, mem_we, wr_e, e_flag, halted, addr_sel, wb_sel, wr_addr,
                       alu_srca, alu_srcb, alu_ctrl, rd_addr_a, rd_addr_b, pc, instr};
                checks++;
                if (((obs ^ want) & msk) !== '0)
                    $display("FAIL rand_cycle: instr#%0d %h cycle %0d got %h want %h mask %h",
                             k, ins, t, obs, want, msk);
                else passed++;
                next_cycle();
            end
            pc0 = take ? pc1 + {{8{ins[7]}}, ins[7:0]} : pc1;
        end
    endtask

    initial begin
        clr = 1'b0; mem_ready = 1'b0; mem_rdata = '0; {c, n, z, v} = 4'h0;
        test_reset();
        test_alu();
        test_ld_wait();
        test_branch();
        test_halt();
        test_mem_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, checks);
        $fatal(1);
    end

endmodule
